// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter sharing the register file write port between ALU and load writeback,
// with a registered write drive and bypass of the in-flight write onto both read ports.
module regfile_write_arbiter #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 4
) (
    input  logic              CLK,
    input  logic              RESET_N,
    input  logic              hold,
    input  logic              req0_valid,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_data,
    input  logic              req1_valid,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_data,
    output logic              gnt0,
    output logic              gnt1,
    output logic [DATA_W-1:0] writeData,
    output logic [ADDR_W-1:0] writeReg,
    output logic              RegWriteControl,
    input  logic [ADDR_W-1:0] read1,
    input  logic [ADDR_W-1:0] read2,
    input  logic [DATA_W-1:0] regOutA,
    input  logic [DATA_W-1:0] regOutB,
    output logic [DATA_W-1:0] bypOutA,
    output logic [DATA_W-1:0] bypOutB,
    output logic              busy
);

    logic              last_q, last_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [ADDR_W-1:0] waddr_q, waddr_d;
    logic              wen_q, wen_d;
    logic              grant_ok;

    // last_q = 1 means port 1 won most recently, so port 0 wins the next contest.
    always_comb begin
        grant_ok = RESET_N & ~hold;
        gnt0     = grant_ok & req0_valid & (~req1_valid | last_q);
        gnt1     = grant_ok & req1_valid & (~req0_valid | ~last_q);
    end

    always_comb begin
        last_d  = last_q;
        wdata_d = wdata_q;
        waddr_d = waddr_q;
        wen_d   = 1'b0;
        if (gnt0) begin
            wdata_d = req0_data;
            waddr_d = req0_addr;
            wen_d   = 1'b1;
            last_d  = 1'b0;
        end else if (gnt1) begin
            wdata_d = req1_data;
            waddr_d = req1_addr;
            wen_d   = 1'b1;
            last_d  = 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            last_q  <= 1'b1;
            wdata_q <= '0;
            waddr_q <= '0;
            wen_q   <= 1'b0;
        end else begin
            last_q  <= last_d;
            wdata_q <= wdata_d;
            waddr_q <= waddr_d;
            wen_q   <= wen_d;
        end
    end

    assign writeData       = wdata_q;
    assign writeReg        = waddr_q;
    assign RegWriteControl = wen_q;

    // The register file commits only at the next edge, so forward the pending write.
    assign bypOutA = (wen_q && (waddr_q == read1)) ? wdata_q : regOutA;
    assign bypOutB = (wen_q && (waddr_q == read2)) ? wdata_q : regOutB;

    assign busy = wen_q | req0_valid | req1_valid;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter: a scoreboard queue holds the writes expected
// on the register-file port, and a small register file model supplies the read data.
module tb_regfile_write_arbiter;

    logic        CLK;
    logic        RESET_N;
    logic        hold;
    logic        req0_valid, req1_valid;
    logic [3:0]  req0_addr, req1_addr;
    logic [15:0] req0_data, req1_data;
    logic        gnt0, gnt1;
    logic [15:0] writeData;
    logic [3:0]  writeReg;
    logic        RegWriteControl;
    logic [3:0]  read1, read2;
    logic [15:0] regOutA, regOutB;
    logic [15:0] bypOutA, bypOutB;
    logic        busy;

    logic [15:0] rf [16];

    typedef struct packed {
        logic [3:0]  a;
        logic [15:0] d;
    } wr_t;

    wr_t sb[$];
    int  checks;
    int  failures;

    regfile_write_arbiter #(.DATA_W(16), .ADDR_W(4)) dut (
        .CLK(CLK),
        .RESET_N(RESET_N),
        .hold(hold),
        .req0_valid(req0_valid),
        .req0_addr(req0_addr),
        .req0_data(req0_data),
        .req1_valid(req1_valid),
        .req1_addr(req1_addr),
        .req1_data(req1_data),
        .gnt0(gnt0),
        .gnt1(gnt1),
        .writeData(writeData),
        .writeReg(writeReg),
        .RegWriteControl(RegWriteControl),
        .read1(read1),
        .read2(read2),
        .regOutA(regOutA),
        .regOutB(regOutB),
        .bypOutA(bypOutA),
        .bypOutB(bypOutB),
        .busy(busy)
    );

    assign regOutA = rf[read1];
    assign regOutB = rf[read2];

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Check grants combinationally and record the write each grant should produce.
    task automatic expect_gnt(input logic e0, input logic e1);
        #1;
        chk("gnt0", 32'(gnt0), 32'(e0));
        chk("gnt1", 32'(gnt1), 32'(e1));
        if (e0) sb.push_back({req0_addr, req0_data});
        if (e1) sb.push_back({req1_addr, req1_data});
        $display("t=%0t grant check exp=%b%b got=%b%b", $time, e0, e1, gnt0, gnt1);
    endtask

    // Register file commits what is on the write port just before the edge; after the
    // edge, the write port must show exactly the next scoreboard entry (or nothing).
    task automatic step();
        wr_t e;
        @(negedge CLK);
        if (RegWriteControl) rf[writeReg] = writeData;
        @(posedge CLK);
        #1;
        chk("rwc", 32'(RegWriteControl), 32'(sb.size() != 0));
        if (sb.size() != 0) begin
            e = sb.pop_front();
            chk("writeReg", 32'(writeReg), 32'(e.a));
            chk("writeData", 32'(writeData), 32'(e.d));
            $display("t=%0t write reg=%0d data=%0h exp reg=%0d data=%0h",
                     $time, writeReg, writeData, e.a, e.d);
        end
    endtask

    task automatic do_reset();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        hold       = 1'b0;
        RESET_N    = 1'b0;
        for (int i = 0; i < 16; i++) rf[i] = 16'h0000;
        rf[1] = 16'h00A5;
        step();
        step();
        RESET_N = 1'b1;
    endtask

    initial begin
        checks     = 0;
        failures   = 0;
        for (int i = 0; i < 16; i++) rf[i] = 16'h0000;
        RESET_N    = 1'b1;
        hold       = 1'b0;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        req0_addr  = 4'd0;
        req0_data  = 16'h0;
        req1_addr  = 4'd0;
        req1_data  = 16'h0;
        read1      = 4'd0;
        read2      = 4'd0;

        // Power-up reset
        #2 RESET_N = 1'b0;
        req0_valid = 1'b1; req0_addr = 4'd3; req0_data = 16'h0003;
        #1;
        chk("rst_gnt0", 32'(gnt0), 32'd0);
        chk("rst_rwc", 32'(RegWriteControl), 32'd0);
        chk("rst_wreg", 32'(writeReg), 32'd0);
        chk("rst_wdata", 32'(writeData), 32'd0);
        chk("rst_busy", 32'(busy), 32'd1);
        req0_valid = 1'b0;
        step();
        step();
        RESET_N = 1'b1;

        // Single request, bypass of in-flight write, then read after commit
        req0_valid = 1'b1; req0_addr = 4'd1; req0_data = 16'h0001;
        read1 = 4'd1;
        expect_gnt(1'b1, 1'b0);
        step();
        req0_valid = 1'b0;
        #1;
        chk("byp_inflight", 32'(bypOutA), 32'h0001);
        chk("busy_inflight", 32'(busy), 32'd1);
        step();
        chk("read_after_commit", 32'(bypOutA), 32'h0001);
        chk("busy_idle", 32'(busy), 32'd0);

        // Reset mid-operation drops the in-flight write
        req0_valid = 1'b1; req0_addr = 4'd5; req0_data = 16'h0007;
        expect_gnt(1'b1, 1'b0);
        step();
        req1_valid = 1'b1; req1_addr = 4'd6; req1_data = 16'h0009;
        #1 RESET_N = 1'b0;
        #1;
        chk("mid_rst_rwc", 32'(RegWriteControl), 32'd0);
        chk("mid_rst_wreg", 32'(writeReg), 32'd0);
        chk("mid_rst_wdata", 32'(writeData), 32'd0);
        chk("mid_rst_gnt0", 32'(gnt0), 32'd0);
        chk("mid_rst_gnt1", 32'(gnt1), 32'd0);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        step();
        read1 = 4'd5;
        #1;
        chk("dropped_write", 32'(bypOutA), 32'h0000);
        RESET_N = 1'b1;

        // Contention: alternation 0,1,0,1 from reset, back-to-back writes
        req0_valid = 1'b1; req0_addr = 4'd2; req0_data = 16'h0008;
        req1_valid = 1'b1; req1_addr = 4'd3; req1_data = 16'h0005;
        expect_gnt(1'b1, 1'b0);
        step();
        req0_addr = 4'd4; req0_data = 16'h0009;
        expect_gnt(1'b0, 1'b1);
        step();
        req1_addr = 4'd6; req1_data = 16'h000A;
        expect_gnt(1'b1, 1'b0);
        step();
        req0_addr = 4'd7; req0_data = 16'h000B;
        expect_gnt(1'b0, 1'b1);
        step();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        expect_gnt(1'b0, 1'b0);
        step();
        // Later contests: port 0 drops valid once granted
        req0_valid = 1'b1; req0_addr = 4'd8; req0_data = 16'h000C;
        req1_valid = 1'b1; req1_addr = 4'd9; req1_data = 16'h000D;
        expect_gnt(1'b1, 1'b0);
        step();
        req0_valid = 1'b0;
        expect_gnt(1'b0, 1'b1);
        step();
        req0_valid = 1'b1; req0_addr = 4'd10; req0_data = 16'h000E;
        req1_addr = 4'd11; req1_data = 16'h000F;
        expect_gnt(1'b1, 1'b0);
        step();
        req0_valid = 1'b0;
        expect_gnt(1'b0, 1'b1);
        step();
        req1_valid = 1'b0;
        step();

        // Same address from reset, with bypass and hold
        do_reset();
        read1 = 4'd2;
        read2 = 4'd1;
        req0_valid = 1'b1; req0_addr = 4'd2; req0_data = 16'h0008;
        req1_valid = 1'b1; req1_addr = 4'd2; req1_data = 16'h0005;
        expect_gnt(1'b1, 1'b0);
        step();
        req0_valid = 1'b0;
        #1;
        chk("bypA", 32'(bypOutA), 32'h0008);
        chk("bypB", 32'(bypOutB), 32'(rf[1]));
        expect_gnt(1'b0, 1'b1);
        step();
        hold = 1'b1;
        req1_addr = 4'd12; req1_data = 16'h0033;
        expect_gnt(1'b0, 1'b0);
        chk("hold_busy", 32'(busy), 32'd1);
        step();
        chk("reg2_final", 32'(bypOutA), 32'h0005);
        expect_gnt(1'b0, 1'b0);
        step();
        expect_gnt(1'b0, 1'b0);
        chk("hold_busy2", 32'(busy), 32'd1);
        step();
        hold = 1'b0;
        expect_gnt(1'b0, 1'b1);
        step();
        req1_valid = 1'b0;
        step();
        chk("sb_empty", 32'(sb.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
